// File: rtl/pll_lock_freq_monitor_pkg.sv
// Shared types and helpers for the PLL lock / output-frequency monitor.
`timescale 1ns/1ps
package pll_mon_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int RES_W_DEF = 3;
  localparam int ABS_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_CHECK     = 3'd4
  } mon_state_e;

  // Both operands are non-negative counts; one extra sign bit keeps the
  // difference exact even when a counter has saturated at all-ones.
  function automatic logic [ABS_W:0] abs_diff(input logic [ABS_W-1:0] a,
                                              input logic [ABS_W-1:0] b);
    logic signed [ABS_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return $unsigned(d);
  endfunction

endpackage

// File: rtl/pll_lock_freq_monitor_if.sv
// Control and status bundle between the monitor and its bench environment.
`timescale 1ns/1ps
interface pll_lock_freq_monitor_if #(
  parameter int N_CH  = 5,
  parameter int CNT_W = 16,
  parameter int RES_W = 3
);
  logic                    start;
  logic                    clear;
  logic                    err_chk;
  logic [RES_W-1:0]        results_cnt;
  logic [N_CH-1:0]         ch_fail;
  logic [N_CH*CNT_W-1:0]   meas_cnt;
  logic                    win_done;
  logic                    lock_seen;

  modport master (
    output start, clear,
    input  err_chk, results_cnt, ch_fail, meas_cnt, win_done, lock_seen
  );

  modport slave (
    input  start, clear,
    output err_chk, results_cnt, ch_fail, meas_cnt, win_done, lock_seen
  );
endinterface

// File: rtl/pll_edge_counter.sv
// Synchronises one asynchronous PLL output clock and counts its rising edges,
// saturating at all-ones; clr holds the count at zero.
`timescale 1ns/1ps
module pll_edge_counter
  import pll_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_tb,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_w;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // s[1:0] is the synchroniser, s[2] holds the previous synchronised level.
  always_comb begin
    s_d    = {s_q[1:0], clk_in};
    edge_w = s_q[1] & ~s_q[2];
    cnt_d  = cnt_q;
    if (clr)         cnt_d = '0;
    else if (edge_w) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pll_lock_freq_monitor.sv
// PLL lock/relock supervisor with windowed per-channel frequency checks and
// a wrapping-saturating error tally.
`timescale 1ns/1ps
module pll_lock_freq_monitor
  import pll_mon_pkg::*;
#(
  parameter int                    N_CH    = 5,
  parameter int                    CNT_W   = CNT_W_DEF,
  parameter int                    WINDOW  = 1000,
  parameter int                    SETTLE  = 256,
  parameter logic [N_CH*CNT_W-1:0] EXP_CNT = {N_CH{CNT_W'(100)}},
  parameter int                    TOL     = 2,
  parameter int                    RES_W   = RES_W_DEF
) (
  input  logic            clk_tb,
  input  logic            rst_n,
  input  logic            pll_lock,
  input  logic [N_CH-1:0] clk_mon,
  pll_lock_freq_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] WIN_LD  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] SET_LD  = CNT_W'(SETTLE - 1);
  localparam logic [ABS_W:0]   TOL_W   = (ABS_W + 1)'(TOL);
  localparam logic [RES_W-1:0] RES_MSB = RES_W'(1) << (RES_W - 1);

  mon_state_e                   state_q, state_d;
  logic [2:0]                   lk_q, lk_d;
  logic [CNT_W-1:0]             timer_q, timer_d;
  logic                         lock_seen_q, lock_seen_d;
  logic                         err_chk_q, err_chk_d;
  logic [RES_W-1:0]             results_q, results_d;
  logic [N_CH-1:0]              ch_fail_q, ch_fail_d;
  logic [N_CH-1:0][CNT_W-1:0]   meas_q, meas_d;
  logic                         win_done_q, win_done_d;

  logic [N_CH-1:0][CNT_W-1:0]   ch_cnt;
  logic [N_CH-1:0]              fail_w;
  logic                         cnt_clr;
  logic                         rise, fall;
  logic                         fall_err, relock_err, chk_err;

  // Once saturated the tally cycles through the upper half so the MSB stays set.
  function automatic logic [RES_W-1:0] res_inc(input logic [RES_W-1:0] v);
    return (&v) ? RES_MSB : v + RES_W'(1);
  endfunction

  // Counters run only while measuring, so each window starts from zero.
  assign cnt_clr = (state_q != ST_MEASURE);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pll_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_tb (clk_tb),
      .rst_n  (rst_n),
      .clk_in (clk_mon[g]),
      .clr    (cnt_clr),
      .cnt    (ch_cnt[g])
    );
  end

  always_comb begin
    lk_d = {lk_q[1:0], pll_lock};
    rise = lk_q[1] & ~lk_q[2];
    fall = ~lk_q[1] & lk_q[2];
  end

  always_comb begin
    fail_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      fail_w[i] = abs_diff(ABS_W'(ch_cnt[i]),
                           ABS_W'(EXP_CNT[i*CNT_W +: CNT_W])) > TOL_W;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    lock_seen_d = lock_seen_q;
    err_chk_d   = 1'b0;
    results_d   = results_q;
    ch_fail_d   = ch_fail_q;
    meas_d      = meas_q;
    win_done_d  = 1'b0;
    chk_err     = 1'b0;
    fall_err    = fall && lock_seen_q &&
                  (state_q inside {ST_SETTLE, ST_MEASURE, ST_CHECK});
    relock_err  = rise && lock_seen_q;

    if (bus.clear) begin
      state_d     = ST_IDLE;
      timer_d     = '0;
      lock_seen_d = 1'b0;
      results_d   = '0;
      ch_fail_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (rise) begin
            state_d     = ST_SETTLE;
            lock_seen_d = 1'b1;
            timer_d     = SET_LD;
          end
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            state_d = ST_MEASURE;
            timer_d = WIN_LD;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (timer_q == '0) state_d = ST_CHECK;
          else               timer_d = timer_q - CNT_W'(1);
        end
        ST_CHECK: begin
          state_d    = ST_MEASURE;
          timer_d    = WIN_LD;
          meas_d     = ch_cnt;
          win_done_d = 1'b1;
          ch_fail_d  = ch_fail_q | fail_w;
          chk_err    = |fail_w;
        end
        default: state_d = ST_IDLE;
      endcase

      // Losing lock discards whatever the current window would have reported.
      if (fall_err) begin
        state_d    = ST_WAIT_LOCK;
        timer_d    = '0;
        meas_d     = meas_q;
        win_done_d = 1'b0;
        ch_fail_d  = ch_fail_q;
        chk_err    = 1'b0;
      end

      err_chk_d = fall_err | relock_err | chk_err;
      if (err_chk_d) results_d = res_inc(results_q);
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lk_q        <= '0;
      timer_q     <= '0;
      lock_seen_q <= 1'b0;
      err_chk_q   <= 1'b0;
      results_q   <= '0;
      ch_fail_q   <= '0;
      meas_q      <= '0;
      win_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lk_q        <= lk_d;
      timer_q     <= timer_d;
      lock_seen_q <= lock_seen_d;
      err_chk_q   <= err_chk_d;
      results_q   <= results_d;
      ch_fail_q   <= ch_fail_d;
      meas_q      <= meas_d;
      win_done_q  <= win_done_d;
    end
  end

  assign bus.err_chk     = err_chk_q;
  assign bus.results_cnt = results_q;
  assign bus.ch_fail     = ch_fail_q;
  assign bus.meas_cnt    = meas_q;
  assign bus.win_done    = win_done_q;
  assign bus.lock_seen   = lock_seen_q;

endmodule

// File: tb/tb_pll_lock_freq_monitor.sv
// Bench for pll_lock_freq_monitor: random PLL output frequencies and lock
// events checked against a window-level model of the expected reports.
`timescale 1ns/1ps
module tb_pll_lock_freq_monitor;

  localparam int N_CH   = 5;
  localparam int CNT_W  = 16;
  localparam int RES_W  = 3;
  localparam int WINDOW = 1000;
  localparam int SETTLE = 256;

  logic            clk_tb;
  logic            rst_n;
  logic            pll_lock;
  wire [N_CH-1:0]  clk_mon;

  pll_lock_freq_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W), .RES_W(RES_W)) bus ();

  pll_lock_freq_monitor #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .WINDOW  (WINDOW),
    .SETTLE  (SETTLE),
    .EXP_CNT ({N_CH{16'd100}}),
    .TOL     (2),
    .RES_W   (RES_W)
  ) u_dut (
    .clk_tb   (clk_tb),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .clk_mon  (clk_mon),
    .bus      (bus)
  );

  // 500 MHz monitor clock: rising edges on odd ns.
  initial begin
    clk_tb = 1'b0;
    forever #1 clk_tb = ~clk_tb;
  end

  // Output clocks: half periods are multiples of 0.5 ns and the start phase is
  // 0.1..0.4 ns, so no clkout edge ever coincides with a clk_tb edge and the
  // edge count over a 2000 ns window is exactly 2000/period.
  real per_ns [N_CH];
  for (genvar g = 0; g < N_CH; g++) begin : g_clk
    logic c;
    initial begin
      c = 1'b0;
      #(0.1 * $urandom_range(1, 4));
      forever #(per_ns[g] / 2.0) c = ~c;
    end
    assign clk_mon[g] = c;
  end

  real ptab [4] = '{16.0, 20.0, 25.0, 40.0};
  int  ctab [4] = '{125, 100, 80, 50};

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int err_seen   = 0;
  int wd_seen    = 0;

  int              exp_cnt [N_CH];
  logic [N_CH-1:0] exp_fail;
  int              n_fail_win;
  int              extra_err;
  int              err_base;

  always @(posedge clk_tb) cyc <= cyc + 1;

  always @(negedge clk_tb) begin
    if (bus.err_chk)  err_seen <= err_seen + 1;
    if (bus.win_done) wd_seen  <= wd_seen + 1;
  end

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Error tally rule: counts 1..7, then cycles 4,5,6,7 once saturated.
  function automatic int res_model(input int n);
    if (n <= 7) return n;
    return 4 + ((n - 8) % 4);
  endfunction

  task automatic wait_win(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_tb);
      if (bus.win_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_model(input logic [2*N_CH-1:0] sel);
    exp_fail = '0;
    for (int i = 0; i < N_CH; i++) begin
      int k;
      k          = int'(sel[2*i +: 2]);
      per_ns[i]  = ptab[k];
      exp_cnt[i] = ctab[k];
      exp_fail[i] = (ctab[k] > 100 + 2) || (ctab[k] < 100 - 2);
    end
    n_fail_win = 0;
    extra_err  = 0;
  endtask

  task automatic arm(input logic [2*N_CH-1:0] sel);
    @(negedge clk_tb);
    bus.clear = 1'b1;
    @(negedge clk_tb);
    bus.clear = 1'b0;
    pll_lock  = 1'b0;
    set_model(sel);
    repeat (20) @(negedge clk_tb);
    bus.start = 1'b1;
    @(negedge clk_tb);
    bus.start = 1'b0;
    repeat (5) @(negedge clk_tb);
    err_base = err_seen;
    pll_lock = 1'b1;
  endtask

  task automatic run_windows(input int n, input bit chk_period);
    int last_c;
    bit ok;
    last_c = 0;
    for (int w = 0; w < n; w++) begin
      wait_win(3000, ok);
      check_val("win_seen", ok, 1);
      if (!ok) return;
      #0.5;
      if (exp_fail != '0) n_fail_win++;
      for (int i = 0; i < N_CH; i++)
        check_val($sformatf("meas_ch%0d", i), bus.meas_cnt[i*CNT_W +: CNT_W], exp_cnt[i]);
      check_val("ch_fail", bus.ch_fail, exp_fail);
      check_val("results_cnt", bus.results_cnt, res_model(n_fail_win + extra_err));
      check_val("err_pulses", err_seen - err_base, n_fail_win + extra_err);
      check_val("lock_seen", bus.lock_seen, 1);
      if (chk_period && w > 0) check_val("win_period", cyc - last_c, WINDOW + 1);
      last_c = cyc;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*N_CH-1:0] sel;
    int c0, w0, e0;

    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    set_model({N_CH{2'd1}});

    // Reset values.
    #10;
    check_val("rst_err_chk", bus.err_chk, 0);
    check_val("rst_results", bus.results_cnt, 0);
    check_val("rst_ch_fail", bus.ch_fail, 0);
    check_val("rst_meas", bus.meas_cnt, 0);
    check_val("rst_win_done", bus.win_done, 0);
    check_val("rst_lock_seen", bus.lock_seen, 0);
    #10 rst_n = 1'b1;

    // Nominal: arm at 100 ns, lock at 500 ns, all channels at 50 MHz.
    #80  bus.start = 1'b1;
    #2   bus.start = 1'b0;
    #398;
    err_base = err_seen;
    pll_lock = 1'b1;
    run_windows(4, 1'b1);

    // One slow channel at 40 MHz.
    arm({2'd1, 2'd1, 2'd2, 2'd1, 2'd1});
    run_windows(2, 1'b1);

    // Random frequency mixes.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_CH; i++) sel[2*i +: 2] = 2'($urandom_range(0, 3));
      arm(sel);
      run_windows(2, 1'b0);
    end

    // Lock drop mid-window: fall and relock errors, interrupted window discarded.
    arm({N_CH{2'd1}});
    run_windows(1, 1'b0);
    c0 = cyc;
    w0 = wd_seen;
    repeat ($urandom_range(100, 800)) @(negedge clk_tb);
    pll_lock = 1'b0;
    #50 pll_lock = 1'b1;
    while (cyc < c0 + WINDOW + 60) @(negedge clk_tb);
    #0.5;
    check_val("no_win_on_drop", wd_seen - w0, 0);
    extra_err = 2;
    run_windows(1, 1'b0);

    // Nine consecutive failing windows exercise the tally wrap.
    arm({2'd1, 2'd1, 2'd1, 2'd1, 2'd3});
    run_windows(9, 1'b0);

    // Clear lands on the CHECK cycle of a failing window.
    arm({2'd1, 2'd1, 2'd1, 2'd2, 2'd1});
    run_windows(1, 1'b0);
    e0 = err_seen;
    w0 = wd_seen;
    repeat (WINDOW) @(posedge clk_tb);
    #0.5 bus.clear = 1'b1;
    @(posedge clk_tb);
    #0.5 bus.clear = 1'b0;
    repeat (3) @(negedge clk_tb);
    #0.5;
    check_val("clr_err_chk", err_seen - e0, 0);
    check_val("clr_results", bus.results_cnt, 0);
    check_val("clr_ch_fail", bus.ch_fail, 0);
    check_val("clr_lock_seen", bus.lock_seen, 0);
    repeat (1200) @(negedge clk_tb);
    #0.5;
    check_val("clr_idle_no_win", wd_seen - w0, 0);

    // Asynchronous reset in the middle of a window.
    arm({2'd1, 2'd0, 2'd1, 2'd1, 2'd1});
    run_windows(1, 1'b0);
    repeat ($urandom_range(100, 800)) @(negedge clk_tb);
    #0.3 rst_n = 1'b0;
    #0.5;
    check_val("arst_err_chk", bus.err_chk, 0);
    check_val("arst_results", bus.results_cnt, 0);
    check_val("arst_ch_fail", bus.ch_fail, 0);
    check_val("arst_meas", bus.meas_cnt, 0);
    check_val("arst_win_done", bus.win_done, 0);
    check_val("arst_lock_seen", bus.lock_seen, 0);
    #9.5 rst_n = 1'b1;
    w0 = wd_seen;
    repeat (1500) @(negedge clk_tb);
    #0.5;
    check_val("post_rst_no_win", wd_seen - w0, 0);
    check_val("post_rst_lock_seen", bus.lock_seen, 0);
    arm({N_CH{2'd1}});
    run_windows(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
